// File: rtl/param_updown_counter_pkg.sv
// Shared types and helpers for the parametrised up/down counter and its prescaler.
package param_updown_counter_pkg;

    typedef enum logic {
        WRAP     = 1'b0,
        SATURATE = 1'b1
    } ctr_mode_e;

    // Prescaler phase width: clog2(PRESCALE), never narrower than one bit.
    function automatic int presc_w(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/param_updown_counter_prescaler.sv
// Divides enabled clocks by PRESCALE, producing a one-clock step_tick.
module ctr_prescaler
    import param_updown_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic en,
    output logic step_tick
);

    localparam int PW = presc_w(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    // With PRESCALE=1 the phase never leaves 0, so step_tick reduces to en.
    always_comb begin
        step_tick = en && (phase_q == LAST);
        phase_d   = phase_q;
        if (restart) begin
            phase_d = '0;
        end else if (step_tick) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter over 0..MAX_VAL with prescaled stepping, clear/load,
// wrap or saturate behaviour and a registered terminal-count pulse.
module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int               PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_min
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             step_tick;
    ctr_mode_e        mode;

    assign mode = ctr_mode_e'(sat_mode);

    ctr_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (clr | load),
        .en        (en),
        .step_tick (step_tick)
    );

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (step_tick) begin
            if (up_dn) begin
                if (count_q < MAX_VAL) begin
                    count_d = count_q + 1'b1;
                    tc_d    = (mode == SATURATE) && (count_q == MAX_VAL - 1'b1);
                end else if (mode == WRAP) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end
            end else begin
                // Saturating at the boundary holds the count without a pulse.
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                    tc_d    = (mode == SATURATE) && (count_q == WIDTH'(1));
                end else if (mode == WRAP) begin
                    count_d = MAX_VAL;
                    tc_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count  = count_q;
    assign tc     = tc_q;
    assign at_max = (count_q == MAX_VAL);
    assign at_min = (count_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench: two counters (PRESCALE 1 and 3, range 0..9) against a behavioural model.
module tb_param_updown_counter;

    localparam int MAXV = 9;

    typedef struct {
        int cnt;
        bit tc;
        bit amax;
        bit amin;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;
    logic       sat_mode = 1'b0;

    logic [3:0] cnt_o  [2];
    logic       tc_o   [2];
    logic       amax_o [2];
    logic       amin_o [2];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   presc  [2] = '{1, 3};
    int   m_cnt  [2] = '{0, 0};
    int   m_ph   [2] = '{0, 0};
    bit   m_tc   [2] = '{0, 0};
    exp_t q0[$];
    exp_t q1[$];

    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
        .count(cnt_o[0]), .tc(tc_o[0]), .at_max(amax_o[0]), .at_min(amin_o[0])
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
        .count(cnt_o[1]), .tc(tc_o[1]), .at_max(amax_o[1]), .at_min(amin_o[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic compare(input int d, input exp_t x);
        check($sformatf("count dut%0d", d), 32'(cnt_o[d]), x.cnt);
        check($sformatf("tc dut%0d", d), 32'(tc_o[d]), 32'(x.tc));
        check($sformatf("at_max dut%0d", d), 32'(amax_o[d]), 32'(x.amax));
        check($sformatf("at_min dut%0d", d), 32'(amin_o[d]), 32'(x.amin));
    endtask

    // Reference: the counter as a number in 0..MAXV, the prescaler as a count of enabled clocks.
    function automatic void model_edge(input int d, input bit c, input bit l, input int lv,
                                       input bit e, input bit u, input bit s);
        m_tc[d] = 0;
        if (c) begin
            m_cnt[d] = 0;
            m_ph[d]  = 0;
        end else if (l) begin
            m_cnt[d] = (lv > MAXV) ? MAXV : lv;
            m_ph[d]  = 0;
        end else if (e) begin
            m_ph[d] = m_ph[d] + 1;
            if (m_ph[d] == presc[d]) begin
                m_ph[d] = 0;
                if (u) begin
                    if (m_cnt[d] == MAXV) begin
                        if (!s) begin
                            m_cnt[d] = 0;
                            m_tc[d]  = 1;
                        end
                    end else begin
                        m_cnt[d] = m_cnt[d] + 1;
                        m_tc[d]  = s && (m_cnt[d] == MAXV);
                    end
                end else begin
                    if (m_cnt[d] == 0) begin
                        if (!s) begin
                            m_cnt[d] = MAXV;
                            m_tc[d]  = 1;
                        end
                    end else begin
                        m_cnt[d] = m_cnt[d] - 1;
                        m_tc[d]  = s && (m_cnt[d] == 0);
                    end
                end
            end
        end
    endfunction

    function automatic exp_t snapshot(input int d);
        exp_t x;
        x.cnt  = m_cnt[d];
        x.tc   = m_tc[d];
        x.amax = (m_cnt[d] == MAXV);
        x.amin = (m_cnt[d] == 0);
        return x;
    endfunction

    task automatic cycle(input bit c, input bit l, input int lv, input bit e, input bit u, input bit s);
        @(negedge clk);
        clr      = c;
        load     = l;
        load_val = 4'(lv);
        en       = e;
        up_dn    = u;
        sat_mode = s;
        for (int d = 0; d < 2; d++) model_edge(d, c, l, lv, e, u, s);
        q0.push_back(snapshot(0));
        q1.push_back(snapshot(1));
    endtask

    task automatic idle_inputs();
        clr  = 1'b0;
        load = 1'b0;
        en   = 1'b0;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                x = q0.pop_front();
                compare(0, x);
            end
            if (q1.size() > 0) begin
                x = q1.pop_front();
                compare(1, x);
            end
        end
    end

    initial begin : driver
        #12;
        for (int d = 0; d < 2; d++) compare(d, snapshot(d));
        @(negedge clk);
        rst_n = 1'b1;

        // Up, wrap, from reset
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 1, 0);
        // Down, wrap, from a clear
        cycle(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 0, 0);
        // Saturate up from 7, then turn around
        cycle(0, 1, 7, 1, 1, 1);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 1);
        // Saturate down into 0 and hold there
        cycle(0, 1, 2, 1, 0, 1);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 0, 1);
        // Prescaler phase held across a gap in en
        cycle(1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 1, 1, 0);
        // Priority and clamping
        cycle(1, 1, 5, 1, 1, 0);
        cycle(0, 1, 15, 1, 1, 0);
        cycle(0, 0, 0, 1, 1, 0);
        cycle(0, 1, 10, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom % 32) == 0, ($urandom % 16) == 0, int'($urandom_range(0, 15)),
                  ($urandom % 4) != 0, $urandom % 2 == 1, ($urandom % 8) < 3);
        end

        // Asynchronous reset between edges at count 6
        cycle(0, 1, 6, 0, 1, 0);
        @(posedge clk);
        #2;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0;
            m_ph[d]  = 0;
            m_tc[d]  = 0;
            compare(d, snapshot(d));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 1, 0);

        @(posedge clk);
        #2;
        check("scoreboard drained dut0", 32'(q0.size()), 0);
        check("scoreboard drained dut1", 32'(q1.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised successor to the team's fixed 4-bit free-running counter. Adds configurable width and modulus, up/down direction, enable with a clock prescaler, synchronous clear and load, wrap or saturate mode, and terminal-count/boundary flags. Used as a general timer/event-count primitive in the datapath and control blocks.

Parameters:
WIDTH, 8, counter width in bits (>=2)
MAX_VAL, 2**WIDTH-1, highest count value; counting range is 0..MAX_VAL inclusive (1 <= MAX_VAL <= 2**WIDTH-1)
PRESCALE, 1, enabled clocks per count step (>=1; 1 = step on every enabled clock)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
clr  in  1  synchronous clear
load  in  1  synchronous load strobe
load_val  in  WIDTH  value for load
en  in  1  count enable (gates the prescaler)
up_dn  in  1  1 = count up, 0 = count down
sat_mode  in  1  0 = wrap at boundaries, 1 = saturate
count  out  WIDTH  current count (registered)
tc  out  1  terminal-count pulse (registered, 1 cycle)
at_max  out  1  count == MAX_VAL (decoded from the count register)
at_min  out  1  count == 0 (decoded from the count register)

Behaviour:
- Reset (rst_n low, asynchronous): count=0, tc=0, prescaler=0. at_min=1 and at_max=0 follow from count.
- Priority on each clock edge: clr > load > step.
- clr: count=0, prescaler=0, tc=0.
- load: count=min(load_val, MAX_VAL), prescaler=0, tc=0. An out-of-range load clamps to MAX_VAL.
- Prescaler: internal counter of width clog2(PRESCALE) (at least 1 bit).
  - When en=1 it increments; step_tick is asserted when prescaler==PRESCALE-1, and the prescaler then returns to 0.
  - en=0 holds the prescaler and count.
  - With PRESCALE=1, step_tick=en.
- Step (step_tick=1, no clr/load):
  - up, count<MAX_VAL: count+1.
  - down, count>0: count-1.
  - up at MAX_VAL, wrap mode: count=0, tc=1.
  - down at 0, wrap mode: count=MAX_VAL, tc=1.
  - Saturate mode, step that arrives at the boundary (MAX_VAL-1 to MAX_VAL up, 1 to 0 down): tc=1.
  - Saturate mode, further steps toward the boundary: count holds, tc=0.
- tc is high only in the cycle after the qualifying edge; otherwise 0.
- up_dn and sat_mode are sampled at each step; changing them mid-run is legal and takes effect on the next step.
- Arithmetic is WIDTH-bit unsigned. Comparisons are against MAX_VAL, never against the natural 2**WIDTH wrap.
- Reset asserted mid-count clears immediately, regardless of clk.

Decomposition:
- Shared package: ctr_mode_e (WRAP=0, SATURATE=1) and a clog2-based helper for the prescaler width.
- One natural sub-module: ctr_prescaler (PRESCALE parameter; en in, step_tick out; clr/load restart).

Test Plan:
- WIDTH=4, MAX_VAL=9, PRESCALE=1, up, wrap, en=1 from reset -> count runs 0..9,0. tc=1 only in the cycle count shows 0 after 9. at_max=1 while count=9.
- Same config, down from reset -> count 0,9,8,...; tc pulses when count becomes 9. at_min=1 only while count=0.
- sat_mode=1, up, load_val=7 then steps -> 8, 9 (tc=1 once), 9, 9... with tc=0. Switch to down -> 8.
- PRESCALE=3, en=1 -> count advances every 3rd clock. Drop en for 5 clocks mid-cycle -> no advance, and the prescaler phase resumes where it stopped.
- Priority: clr=1, load=1, load_val=5 in the same cycle -> count=0. Then load_val=15 with MAX_VAL=9 -> count=9 (clamped), tc=0.
- Assert rst_n low asynchronously between clock edges at count=6 -> count=0 and tc=0 immediately. After release, counting resumes from 0.
